// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester port IDs and default geometry.
package dmem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Combinational; the caller owns the last-grant
// register so the same picker can front any shared resource.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_winner
);

  // Lone requester wins; on a tie the port that did not win last time goes.
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = PORT_CPU;
    if (i_req0 && i_req1)
      o_winner = ~i_last_grant;
    else if (i_req1)
      o_winner = PORT_DMA;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store stage (port 0) and the DMA/debug loader (port 1). Each access
// is a fixed IDLE -> ACCESS -> RESP transaction. Optional range check on the
// granted address is built when DMEM_ARB_RANGE_CHECK_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t              r_state;
  state_t              w_next;
  logic                r_gnt;
  logic                r_last_grant;
  logic                r_ack0, r_ack1;
  logic                r_err0, r_err1;
  logic                r_oor;
  logic                r_mem_read, r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_busy;

  logic                w_valid;
  logic                w_winner;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_oor;

  rr_arb2 u_rr (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  // Steer the winning port's command toward the memory registers.
  always_comb begin
    w_we    = w_winner ? we1    : we0;
    w_addr  = w_winner ? addr1  : addr0;
    w_wdata = w_winner ? wdata1 : wdata0;
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign w_oor = (64'(w_addr) >= 64'(DEPTH));
`else
  assign w_oor = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: requests only matter in IDLE; the rest is a fixed walk.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_valid) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Registered outputs: memory command issued leaving IDLE, dropped leaving
  // ACCESS (the memory acts on that edge), ack held for the RESP cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt        <= PORT_CPU;
      r_last_grant <= PORT_DMA;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_oor        <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_err0 <= 1'b0;
          r_err1 <= 1'b0;
          if (w_valid) begin
            r_gnt        <= w_winner;
            r_last_grant <= w_winner;
            r_mem_addr   <= w_addr;
            r_mem_wdata  <= w_wdata;
            r_mem_read   <= ~w_we & ~w_oor;
            r_mem_write  <=  w_we & ~w_oor;
            r_oor        <= w_oor;
            r_busy       <= 1'b1;
          end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
          end
        end
        ST_ACCESS: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_ack0      <= (r_gnt == PORT_CPU);
          r_ack1      <= (r_gnt == PORT_DMA);
          r_err0      <= (r_gnt == PORT_CPU) & r_oor;
          r_err1      <= (r_gnt == PORT_DMA) & r_oor;
          r_busy      <= 1'b1;
        end
        ST_RESP: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_err0 <= 1'b0;
          r_err1 <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_ack0      <= 1'b0;
          r_ack1      <= 1'b0;
          r_err0      <= 1'b0;
          r_err1      <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign err0      = r_err0;
  assign err1      = r_err1;
  assign mem_addr  = r_mem_addr;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

  // Read data is the memory's registered output, routed only to the acked
  // port; an errored access returns zero.
  assign rdata0 = (r_ack0 && !r_err0) ? mem_rdata : '0;
  assign rdata1 = (r_ack1 && !r_err1) ? mem_rdata : '0;

  // The granted requester must hold req until its ack has been seen.
  a_req0_held: assert property (@(posedge clock) disable iff (reset)
    (r_state != ST_IDLE && r_gnt == PORT_CPU) |-> req0);
  a_req1_held: assert property (@(posedge clock) disable iff (reset)
    (r_state != ST_IDLE && r_gnt == PORT_DMA) |-> req1);

  // Implemented depth must fit inside the address space.
  a_depth_fits: assert property (@(posedge clock)
    64'(DEPTH) <= (64'd1 << ADDR_W));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data_memory.
// Honours DMEM_ARB_RANGE_CHECK_EN for the out-of-range expectations.
module tb_dmem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 1024;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // data_memory: no reset, registered read port.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clock) begin
    if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[9:0]];
  end

  typedef struct packed {
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic [DW-1:0] sh [0:DEPTH-1];
  exp_t q0[$], q1[$];
  int   order_q[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: pop the per-port scoreboard on each ack, check ack width,
  // exclusivity, idle rdata, busy run length and forbidden memory reads.
  logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;
  int   brun = 0;
  bit   babort = 1'b0;
  bit   oor_seen = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (ack0) begin
        chk("ack0_width", prev_ack0, 0);
        chk("ack_excl", ack1, 0);
        chk("rdata1_idle", rdata1, 0);
        if (q0.size() == 0) chk("ack0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          chk("err0", err0, e.err);
          if (!e.we) chk("rdata0", rdata0, e.rdata);
        end
        order_q.push_back(0);
      end
      if (ack1) begin
        chk("ack1_width", prev_ack1, 0);
        chk("rdata0_idle", rdata0, 0);
        if (q1.size() == 0) chk("ack1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("err1", err1, e.err);
          if (!e.we) chk("rdata1", rdata1, e.rdata);
        end
        order_q.push_back(1);
      end
    end
    if (busy) begin
      brun++;
      if (reset) babort = 1'b1;
    end else begin
      if (brun != 0 && !babort) chk("busy_len", brun, 2);
      brun = 0;
      babort = 1'b0;
    end
    if (mem_read && mem_addr >= AW'(DEPTH)) oor_seen = 1'b1;
    prev_ack0 = ack0;
    prev_ack1 = ack1;
  end

  // Drive one command on port p, hold req until ack, release at E2.
  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit chk_lat);
    exp_t e;
    int   k;
    logic seen;
    e.we    = we;
    e.err   = 1'b0;
    e.rdata = sh[a[9:0]];
`ifdef DMEM_ARB_RANGE_CHECK_EN
    if (a >= AW'(DEPTH)) begin
      e.err   = 1'b1;
      e.rdata = '0;
    end
`endif
    if (we && !e.err) sh[a[9:0]] = d;
    if (p == 0) begin
      q0.push_back(e);
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      q1.push_back(e);
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clock); #1;
      k++;
      seen = (p == 0) ? ack0 : ack1;
    end
    if (!seen) chk($sformatf("timeout_p%0d", p), 1, 0);
    if (chk_lat) chk($sformatf("latency_p%0d", p), k, 2);
    @(posedge clock); #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(i * 3);
      sh[i]  = DW'(i * 3);
    end
    mem[1] = 16'd10;
    sh[1]  = 16'd10;

    // Reset state
    @(posedge clock); #1;
    do_reset();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_err", {err0, err1}, 0);
    chk("rst_memcmd", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);

    // Port-1 read of preloaded word
    issue(1, 1'b0, 16'd1, 16'd0, 1'b1);

    // Port-0 write then read-back
    issue(0, 1'b1, 16'd5, 16'h00AB, 1'b1);
    issue(0, 1'b0, 16'd5, 16'd0, 1'b1);

    // Simultaneous requests straight after reset: port 0 first
    do_reset();
    order_q.delete();
    fork
      issue(0, 1'b1, 16'd2, 16'd7, 1'b0);
      issue(1, 1'b1, 16'd3, 16'd9, 1'b0);
    join
    chk("simul_len", order_q.size(), 2);
    if (order_q.size() == 2) begin
      chk("simul_first", order_q[0], 0);
      chk("simul_second", order_q[1], 1);
    end
    issue(0, 1'b0, 16'd2, 16'd0, 1'b1);
    issue(1, 1'b0, 16'd3, 16'd0, 1'b1);

    // Continuous contention: strict alternation over 8 grants
    do_reset();
    order_q.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b1, AW'(40 + i), DW'(i + 100), 1'b0);
      end
      begin
        for (int j = 0; j < 4; j++) issue(1, 1'b0, 16'd1, 16'd0, 1'b0);
      end
    join
    chk("order_len", order_q.size(), 8);
    for (int i = 0; i < order_q.size() && i < 8; i++)
      chk($sformatf("order%0d", i), order_q[i], i % 2);
    issue(1, 1'b0, 16'd43, 16'd0, 1'b1);

    // Reset asserted at E1 of a port-0 write: no ack, write still lands
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'd4; wdata0 = 16'd33;
    @(posedge clock); #1;
    chk("rstmid_mem_write", mem_write, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rstmid_ack0", ack0, 0);
    chk("rstmid_busy", busy, 0);
    reset = 1'b0;
    req0 = 1'b0;
    sh[4] = 16'd33;
    @(posedge clock); #1;
    chk("rstmid_ack0_after", ack0, 0);
    issue(0, 1'b0, 16'd4, 16'd0, 1'b1);

    // Out-of-range address on port 1
    oor_seen = 1'b0;
    issue(1, 1'b0, 16'd1024, 16'd0, 1'b1);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    chk("oor_no_mem_read", oor_seen, 0);
`endif

    repeat (3) @(posedge clock);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
